// File: rtl/memtest_pkg.sv
// Shared types for the SDRAM memory-test sequencer: data patterns, FSM state codes
// and the LFSR step used by both pattern generators.
package memtest_pkg;

  typedef enum logic [1:0] {
    PAT_ADDR     = 2'd0,
    PAT_CHECKER  = 2'd1,
    PAT_INV_ADDR = 2'd2,
    PAT_LFSR     = 2'd3
  } pattern_e;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_WRITE = 4'd1,
    ST_READ  = 4'd2,
    ST_DRAIN = 4'd3,
    ST_NEXT  = 4'd4
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Right-shifting Galois step.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/memtest_if.sv
// Request/ack word interface between the test sequencer and the SDRAM controller.
// Reads return in issue order on rvalid/rdata.
interface memtest_if #(
  parameter int ADDR_W = 24
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic              ack;
  logic              rvalid;
  logic [15:0]       rdata;

  modport master (output req, we, addr, wdata, input ack, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rvalid, rdata);
endinterface

// File: rtl/memtest_patgen.sv
// Test-pattern word generator for one address stream. The LFSR state is private
// to each instance so the issue and check sides can run independently.
module memtest_patgen
  import memtest_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  pattern_e          pattern,
  input  logic              load,
  input  logic [15:0]       seed,
  input  logic              advance,
  output logic [15:0]       data
);

  logic [15:0] lfsr;
  logic [31:0] addr_ext;
  logic [15:0] addr_fold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       lfsr <= '0;
    else if (load)    lfsr <= seed;
    else if (advance) lfsr <= lfsr_next(lfsr);
  end

  // Bank/row bits above bit 15 are folded into the low half.
  assign addr_ext  = 32'(addr);
  assign addr_fold = addr_ext[15:0] ^ addr_ext[31:16];

  always_comb begin
    data = addr_fold;
    case (pattern)
      PAT_ADDR:     data = addr_fold;
      PAT_CHECKER:  data = addr[0] ? 16'h5555 : 16'hAAAA;
      PAT_INV_ADDR: data = ~addr_fold;
      PAT_LFSR:     data = lfsr;
      default:      data = addr_fold;
    endcase
  end

endmodule

// File: rtl/memtest_sequencer.sv
// SDRAM test sequencer: full-array write then pipelined read-verify, once per pattern,
// accumulating pass/fail counters for the result display.
//
// state | meaning
// IDLE  | stopped; counters hold, waiting for run
// WRITE | writing every word of the current pattern
// READ  | issuing reads, at most RD_DEPTH in flight
// DRAIN | no new requests; waiting for all reads to return
// NEXT  | advance pattern, bump passcount after the last pattern
module memtest_sequencer
  import memtest_pkg::*;
#(
  parameter  int DRAM_COL_SIZE = 9,
  parameter  int DRAM_ROW_SIZE = 13,
  parameter  int RD_DEPTH      = 4,
  localparam int ADDR_W        = DRAM_COL_SIZE + DRAM_ROW_SIZE + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  memtest_if.master         mem,
  output logic [31:0]       passcount,
  output logic [31:0]       failcount,
  output logic [3:0]        mmtst_state,
  output logic [ADDR_W-1:0] err_addr,
  output logic              proto_err
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_e            state, state_nx;
  pattern_e          pat;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] chk_addr;
  logic [3:0]        outstanding;
  logic [15:0]       wdata_gen;
  logic [15:0]       chk_data;
  logic [15:0]       seed;
  logic              rd_room, wr_acc, rd_acc, rd_ret, wr_load, rd_load;

  assign rd_room = outstanding < 4'(RD_DEPTH);
  assign wr_acc  = (state == ST_WRITE) && mem.ack;
  assign rd_acc  = (state == ST_READ) && rd_room && mem.ack;
  assign rd_ret  = mem.rvalid && (outstanding != 4'd0);
  assign seed    = {passcount[14:0], 1'b1};
  assign wr_load = (state_nx == ST_WRITE) && (state != ST_WRITE);
  assign rd_load = (state_nx == ST_READ) && (state != ST_READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mem.req  = 1'b0;
    mem.we   = 1'b0;
    case (state)
      ST_IDLE:  if (run) state_nx = ST_WRITE;
      ST_WRITE: begin
        mem.req = 1'b1;
        mem.we  = 1'b1;
        if (mem.ack && addr == LAST) state_nx = ST_READ;
      end
      ST_READ: begin
        mem.req = rd_room;
        if (rd_acc && addr == LAST) state_nx = ST_DRAIN;
      end
      ST_DRAIN: if (outstanding == 4'd0) state_nx = ST_NEXT;
      ST_NEXT:  state_nx = run ? ST_WRITE : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign mem.addr    = addr;
  assign mem.wdata   = (state == ST_WRITE) ? wdata_gen : 16'h0000;
  assign mmtst_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr        <= '0;
      chk_addr    <= '0;
      outstanding <= '0;
      pat         <= PAT_ADDR;
      passcount   <= '0;
      failcount   <= '0;
      err_addr    <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (wr_load)               addr <= '0;
      else if (wr_acc || rd_acc) addr <= addr + 1'b1;

      // A read issued and one returned in the same cycle cancel out.
      case ({rd_acc, rd_ret})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase

      if (rd_ret) begin
        chk_addr <= chk_addr + 1'b1;
        if (mem.rdata != chk_data) begin
          err_addr <= chk_addr;
          if (failcount != 32'hFFFF_FFFF) failcount <= failcount + 32'd1;
        end
      end

      if (mem.rvalid && outstanding == 4'd0) proto_err <= 1'b1;

      if (state == ST_NEXT) begin
        pat <= pattern_e'(pat + 2'd1);
        if (pat == PAT_LFSR) passcount <= passcount + 32'd1;
      end
    end
  end

  memtest_patgen #(.ADDR_W(ADDR_W)) u_issue_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .pattern (pat),
    .load    (wr_load),
    .seed    (seed),
    .advance (wr_acc),
    .data    (wdata_gen)
  );

  memtest_patgen #(.ADDR_W(ADDR_W)) u_check_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (chk_addr),
    .pattern (pat),
    .load    (rd_load),
    .seed    (seed),
    .advance (rd_ret),
    .data    (chk_data)
  );

endmodule

// File: tb/tb_memtest_sequencer.sv
// Bench for memtest_sequencer on a 64-word array with a behavioural SDRAM model,
// random ack stalls and variable in-order read latency.
module tb_memtest_sequencer;

  localparam int RD_DEPTH = 4;
  localparam int WORDS    = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] passcount, failcount;
  logic [3:0]  mmtst_state;
  logic [5:0]  err_addr;
  logic        proto_err;

  memtest_if #(.ADDR_W(6)) mem_bus ();

  memtest_sequencer #(
    .DRAM_COL_SIZE (2),
    .DRAM_ROW_SIZE (2),
    .RD_DEPTH      (RD_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .mem         (mem_bus),
    .passcount   (passcount),
    .failcount   (failcount),
    .mmtst_state (mmtst_state),
    .err_addr    (err_addr),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected word for pattern p at address a, LFSR derived by stepping from seed a times.
  function automatic logic [15:0] pat_word(input int p, input int a, input logic [15:0] seed);
    logic [15:0] v;
    v = 16'(a) ^ 16'(a >> 16);
    case (p)
      1: v = (a % 2 == 1) ? 16'h5555 : 16'hAAAA;
      2: v = ~v;
      3: begin
        v = seed;
        for (int i = 0; i < a; i++) v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
      end
      default: ;
    endcase
    return v;
  endfunction

  // test knobs (written by the stimulus block only)
  logic        ack_rand = 1'b0;
  logic        lat_rand = 1'b0;
  logic [63:0] corrupt_map = '0;
  int          corrupt_pat = 0;
  logic        inj_rvalid = 1'b0;

  // SDRAM model state (written by the model only)
  typedef struct {int a; int ready;} rd_t;
  rd_t         rq[$];
  logic [15:0] mem_arr [WORDS];
  int          cyc = 0, wr_idx = 0, rd_idx = 0, rd_done = 0, exp_pat = 0;
  logic [31:0] exp_pass = '0;
  int          n_mis = 0, last_mis = 0, req_cnt = 0, max_out = 0;
  int          wr_first = 0, wr_span = 0;
  int          bad_state = 0, bad_hold = 0, bad_depth = 0, bad_wdata = 0, bad_waddr = 0, bad_raddr = 0;
  logic        stall_prev = 1'b0;
  logic [23:0] prev_word = '0;
  logic        ack_now, rv_now;
  logic [15:0] rd_now, d;
  int          a, lat, rdy;

  always @(negedge clk) begin
    if (!rst_n) begin
      rq.delete();
      wr_idx = 0; rd_idx = 0; rd_done = 0; exp_pat = 0; exp_pass = '0;
      n_mis = 0; last_mis = 0; stall_prev = 1'b0;
      mem_bus.ack = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
    end else begin
      cyc++;
      if (mem_bus.req) begin
        req_cnt++;
        if (!(mmtst_state inside {4'd1, 4'd2})) bad_state++;
        if (!mem_bus.we && rq.size() >= RD_DEPTH) bad_depth++;
      end
      if (rq.size() > max_out) max_out = rq.size();
      if (stall_prev && {mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.wdata} != prev_word) bad_hold++;

      ack_now = ack_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      rv_now  = inj_rvalid;
      rd_now  = '0;
      if (rq.size() > 0 && rq[0].ready <= cyc) begin
        a = rq[0].a;
        rq.pop_front();
        d = mem_arr[a];
        if (corrupt_map[a] && exp_pat == corrupt_pat) begin
          d = d ^ 16'h0001;
          n_mis++;
          last_mis = a;
        end
        rv_now = 1'b1;
        rd_now = d;
        rd_done++;
        if (rd_done == WORDS) begin
          rd_done = 0;
          exp_pat = (exp_pat + 1) % 4;
          if (exp_pat == 0) exp_pass = exp_pass + 1;
        end
      end

      if (mem_bus.req && ack_now) begin
        if (mem_bus.we) begin
          if (mem_bus.addr != 6'(wr_idx)) bad_waddr++;
          if (mem_bus.wdata != pat_word(exp_pat, wr_idx, {exp_pass[14:0], 1'b1})) bad_wdata++;
          mem_arr[mem_bus.addr] = mem_bus.wdata;
          if (wr_idx == 0) wr_first = cyc;
          if (wr_idx == WORDS - 1) wr_span = cyc - wr_first + 1;
          wr_idx = (wr_idx + 1) % WORDS;
        end else begin
          if (mem_bus.addr != 6'(rd_idx)) bad_raddr++;
          lat = lat_rand ? int'($urandom_range(1, 6)) : 3;
          rdy = cyc + lat;
          if (rq.size() > 0 && rdy <= rq[$].ready) rdy = rq[$].ready + 1;
          rq.push_back('{a: int'(mem_bus.addr), ready: rdy});
          rd_idx = (rd_idx + 1) % WORDS;
        end
      end

      stall_prev = mem_bus.req && !ack_now;
      prev_word  = {mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.wdata};
      mem_bus.ack    = ack_now;
      mem_bus.rvalid = rv_now;
      mem_bus.rdata  = rd_now;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_pass(input int target, input int lim, input string tag);
    int n = 0;
    while (exp_pass < 32'(target) && n < lim) begin step(1); n++; end
    chk(tag, 32'(n < lim), 32'd1);
  endtask

  task automatic wait_state(input logic [3:0] s, input int lim, input string tag);
    int n = 0;
    while (mmtst_state != s && n < lim) begin step(1); n++; end
    chk(tag, 32'(n < lim), 32'd1);
  endtask

  task automatic chk_monitor(input string tag);
    chk({tag, "_req_state"}, 32'(bad_state), 32'd0);
    chk({tag, "_stall_hold"}, 32'(bad_hold), 32'd0);
    chk({tag, "_rd_depth"}, 32'(bad_depth), 32'd0);
    chk({tag, "_wdata"}, 32'(bad_wdata), 32'd0);
    chk({tag, "_waddr"}, 32'(bad_waddr), 32'd0);
    chk({tag, "_raddr"}, 32'(bad_raddr), 32'd0);
  endtask

  initial begin
    int n, rc;
    rst_n = 1'b0;
    run   = 1'b0;
    step(3);
    chk("rst_passcount", passcount, 32'd0);
    chk("rst_failcount", failcount, 32'd0);
    chk("rst_state", 32'(mmtst_state), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_req", 32'(mem_bus.req), 32'd0);
    rst_n = 1'b1;
    step(2);
    chk("idle_no_run_state", 32'(mmtst_state), 32'd0);

    // 1: ack always high, fixed latency, one full pass
    run = 1'b1;
    wait_pass(1, 3000, "t1_timeout");
    wait_state(4'd1, 50, "t1_state_timeout");
    chk("t1_passcount", passcount, 32'd1);
    chk("t1_failcount", failcount, 32'd0);
    chk("t1_state", 32'(mmtst_state), 32'd1);
    chk("t1_wr_span", 32'(wr_span), 32'd64);
    chk_monitor("t1");

    // 2: bit 0 flipped at 0x15 in pattern 1
    corrupt_map[21] = 1'b1;
    corrupt_pat     = 1;
    wait_pass(2, 3000, "t2_timeout");
    step(3);
    chk("t2_failcount", failcount, 32'd1);
    chk("t2_err_addr", 32'(err_addr), 32'h15);
    corrupt_map = '0;

    // 3: random stalls and latency for three passes
    ack_rand = 1'b1;
    lat_rand = 1'b1;
    wait_pass(5, 30000, "t3_timeout");
    step(3);
    chk("t3_failcount", failcount, 32'd1);
    chk("t3_passcount", passcount, 32'd5);
    chk("t3_max_out", 32'(max_out <= RD_DEPTH), 32'd1);
    chk_monitor("t3");

    // 4: drop run mid-READ of pattern 2, then resume on pattern 3
    n = 0;
    while (!(exp_pat == 2 && mmtst_state == 4'd2 && rd_idx >= 20) && n < 5000) begin step(1); n++; end
    chk("t4_mid_read_timeout", 32'(n < 5000), 32'd1);
    run = 1'b0;
    wait_state(4'd0, 2000, "t4_idle_timeout");
    chk("t4_state_idle", 32'(mmtst_state), 32'd0);
    chk("t4_passcount", passcount, 32'd5);
    rc = req_cnt;
    step(40);
    chk("t4_idle_req", 32'(req_cnt - rc), 32'd0);
    chk("t4_idle_state_held", 32'(mmtst_state), 32'd0);
    run = 1'b1;
    wait_state(4'd1, 20, "t4_resume_timeout");
    chk("t4_first_addr", 32'(mem_bus.addr), 32'd0);
    chk("t4_lfsr_seed", 32'(mem_bus.wdata), 32'h000B);

    // 5: stray rvalid in IDLE, then reset mid-WRITE
    run = 1'b0;
    wait_state(4'd0, 4000, "t5_idle_timeout");
    chk("t5_proto_before", 32'(proto_err), 32'd0);
    inj_rvalid = 1'b1;
    step(1);
    inj_rvalid = 1'b0;
    chk("t5_proto_set", 32'(proto_err), 32'd1);
    step(10);
    chk("t5_proto_sticky", 32'(proto_err), 32'd1);
    chk("t5_failcount_held", failcount, 32'd1);
    chk("t5_err_addr_held", 32'(err_addr), 32'h15);
    run = 1'b1;
    n = 0;
    while (!(mmtst_state == 4'd1 && wr_idx >= 5) && n < 200) begin step(1); n++; end
    chk("t5_mid_write_timeout", 32'(n < 200), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_passcount", passcount, 32'd0);
    chk("t5_rst_failcount", failcount, 32'd0);
    chk("t5_rst_state", 32'(mmtst_state), 32'd0);
    chk("t5_rst_err_addr", 32'(err_addr), 32'd0);
    chk("t5_rst_proto_err", 32'(proto_err), 32'd0);
    chk("t5_rst_bus", {8'h0, mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.wdata}, 32'd0);
    step(2);
    ack_rand = 1'b0;
    lat_rand = 1'b0;
    rst_n    = 1'b1;

    // 6: saturation of failcount from a preloaded value
    corrupt_map[3]  = 1'b1;
    corrupt_map[20] = 1'b1;
    corrupt_map[40] = 1'b1;
    corrupt_pat     = 0;
    wait_state(4'd1, 20, "t6_write_timeout");
    force dut.failcount = 32'hFFFF_FFFE;
    #1;
    release dut.failcount;
    n = 0;
    while (exp_pat != 1 && n < 1000) begin step(1); n++; end
    chk("t6_pattern_timeout", 32'(n < 1000), 32'd1);
    step(3);
    chk("t6_failcount_sat", failcount, 32'hFFFF_FFFF);
    chk("t6_err_addr", 32'(err_addr), 32'd40);
    chk("t6_passcount", passcount, 32'd0);
    chk_monitor("end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
